cc_block_gen: RTL and testbench
===============================

# cc_block_gen

Parametrised ChaCha keystream generator: the next generation of the single-block iterative `cc_block`. It runs the RFC 8439 ChaCha state over a configurable round count, with a configurable number of quarter-round units per cycle. One start produces `NBLK` consecutive 512-bit blocks with automatic counter increment. Output uses a valid/ready handshake. It sits between the key/nonce setup logic and the Poly1305 key derivation and payload XOR stages.

## Interface
- `ROUNDS`, 20, total rounds; even, 8..20.
- `QR_PAR`, 1, quarter-rounds evaluated per cycle; one of 1, 2, 4.
- `NBLK`, 1, blocks generated per start; 1..255.
- `i_clk`  in  1  clock, rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_start`  in  1  start pulse; sampled only in IDLE.
- `i_abort`  in  1  synchronous abort to IDLE.
- `i_hmode`  in  1  HChaCha mode select (see Configuration).
- `i_key`  in  256  key; word i = `i_key[32i+31:32i]`.
- `i_non`  in  96  nonce; word 13+j = `i_non[32j+31:32j]`.
- `i_cnt`  in  32  initial block counter.
- `o_stream`  out  512  block; state word i on `[32i+31:32i]`.
- `o_valid`  out  1  `o_stream` valid.
- `i_ready`  in  1  consumer accepts the block.
- `o_cnt`  out  32  counter value of the block on `o_stream`.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_done`  out  1  one-cycle pulse after the last block is accepted.
- `o_wrap`  out  1  sticky: the counter wrapped during this job.

## Operation
- FSM states: IDLE, ROUND, ADD, OUT.
- On a reset edge, all state clears. Every output resets to 0 and the FSM enters IDLE.
- **IDLE:** on `i_start`, latch key, nonce, counter and mode, then load the state:
  - words 0–3 = 61707865, 3320646e, 79622d32, 6b206574
  - words 4–11 = key
  - word 12 = counter
  - words 13–15 = nonce
  - Clear `o_wrap`, set the block counter to 0, go to ROUND.
- After the latch, input ports may change freely.
- **ROUND:** each cycle applies `QR_PAR` quarter-rounds.
  - Order: columns (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15), then diagonals (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
  - The sequence repeats until `ROUNDS/2` double rounds are complete.
  - All adds are mod 2^32; rotations are 16, 12, 8, 7.
  - ROUND lasts R = `ROUNDS`*4/`QR_PAR` cycles.
- **ADD:** one cycle. Add the latched initial state word-wise mod 2^32, register the result into `o_stream`, then go to OUT.
- **OUT:** `o_valid`=1. `o_stream` and `o_cnt` stay stable until `o_valid`&&`i_ready`. On transfer:
  - If blocks emitted < `NBLK`: counter ← counter+1 mod 2^32, reload the state with the new counter, go to ROUND.
  - Otherwise: pulse `o_done`, go to IDLE.
- Counter wrap: when 0xFFFFFFFF increments to 0, set `o_wrap`. Generation continues.
- `i_abort` in any state returns to IDLE next cycle. Effects: `o_valid`=0, no `o_done`, `o_stream` is kept.
- `i_start` outside IDLE is ignored. When `i_abort` and `i_start` are both high in IDLE, `i_abort` wins and no job starts.

## Timing
- The start edge is t. ROUND occupies t+1..t+R, ADD is t+R+1, and `o_valid` rises at t+R+2.
  - Defaults: first `o_valid` 82 cycles after start.
  - `QR_PAR`=4, `ROUNDS`=8: 10 cycles.
- With `i_ready` held high, subsequent blocks follow every R+2 cycles.
- `o_done` is high for the cycle after the final transfer edge. `o_busy` falls in the same cycle.
- `o_valid` never drops without either a transfer or `i_abort`.

## Configuration
- `CC_HCHACHA_EN` defined:
  - When `i_hmode`=1 at start, the ADD stage skips the feed-forward add.
  - `o_stream[255:0]` = round-state words 0–3, 12–15; `o_stream[511:256]` = 0.
  - Exactly one block is produced regardless of `NBLK`.
  - `o_cnt` = latched `i_cnt`.
- `CC_HCHACHA_EN` undefined: `i_hmode` is ignored and the HChaCha logic is not synthesised.

## Test plan
- **RFC 8439 §2.3.2 vector.** Stimulus: key 1f1e…03020100, nonce 00000000_4a000000_09000000, cnt 1, defaults. Required:
  - word0=e4e7f110, word1=15593bd1, word15=4e3c50a2
  - `o_valid` rises 82 cycles after start; `o_cnt`=1.
- **Multi-block with backpressure.** Stimulus: `NBLK`=3, cnt 1, `i_ready` low for 5 cycles at each OUT. Required:
  - `o_stream` is stable while stalled.
  - `o_cnt` sequence is 1, 2, 3.
  - One `o_done` after the third transfer.
- **Counter wrap.** Stimulus: `NBLK`=2, cnt FFFFFFFF. Required: `o_cnt` sequence FFFFFFFF then 00000000; `o_wrap`=1 from the second block until the next start.
- **Parallelism check.** Stimulus: `QR_PAR`=4 with the vector above. Required: identical words; `o_valid` at t+22.
- **Abort and reset.** Stimulus: `i_abort` during ROUND, then a new start; separately, `i_rst` asserted mid-OUT. Required:
  - Abort: IDLE next cycle, no `o_done`, the new job is correct.
  - Reset: all outputs 0 immediately.
- **HChaCha (`CC_HCHACHA_EN`).** Stimulus: `i_hmode`=1 with the §2.3.2 inputs. Required: `o_stream[31:0]`=837778ab, word 4 of output (state word 12)=d19c12b4, upper 256 bits 0.

Source files
------------

// File: rtl/cc_block_gen.sv
// ChaCha keystream generator: NBLK blocks per start, QR_PAR quarter-rounds per cycle.
// Define CC_HCHACHA_EN to build the HChaCha output mode selected by i_hmode.
module cc_block_gen #(
    parameter int ROUNDS = 20,
    parameter int QR_PAR = 1,
    parameter int NBLK   = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic         i_hmode,
    input  logic [255:0] i_key,
    input  logic [95:0]  i_non,
    input  logic [31:0]  i_cnt,
    output logic [511:0] o_stream,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [31:0]  o_cnt,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_wrap
);

    localparam int R   = ROUNDS * 4 / QR_PAR;
    localparam int RW  = $clog2(R);
    localparam int GRP = 8 / QR_PAR;
    localparam int GB  = $clog2(GRP);

    typedef enum logic [1:0] {IDLE, ROUND, ADD, OUT} fsm_t;

    fsm_t              fsm;
    logic [15:0][31:0] x;
    logic [15:0][31:0] x0;
    logic [15:0][31:0] nx;
    logic [15:0][31:0] sum;
    logic [15:0][31:0] load;
    logic [RW-1:0]     rcnt;
    logic [7:0]        blk;
    logic              more;
    logic              last_rnd;
    logic [2:0]        q;
    logic [15:0]       ix;
    logic [127:0]      r;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] c,
        input logic [31:0] d
    );
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    // Word index = {row, column}; diagonals shift the column by the row number.
    function automatic logic [15:0] qidx(input logic [2:0] qn);
        logic [1:0] c;
        c = qn[1:0];
        if (qn[2])
            return {2'd0, c, 2'd1, c + 2'd1, 2'd2, c + 2'd2, 2'd3, c + 2'd3};
        return {2'd0, c, 2'd1, c, 2'd2, c, 2'd3, c};
    endfunction

    assign load = {i_non, i_cnt, i_key,
                   32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

    assign last_rnd = (rcnt == RW'(R - 1));

    always_comb begin
        nx = x;
        q  = '0;
        ix = '0;
        r  = '0;
        for (int k = 0; k < QR_PAR; k++) begin
            q  = 3'(int'(rcnt[GB-1:0]) * QR_PAR + k);
            ix = qidx(q);
            r  = qr(x[ix[15:12]], x[ix[11:8]], x[ix[7:4]], x[ix[3:0]]);
            nx[ix[15:12]] = r[127:96];
            nx[ix[11:8]]  = r[95:64];
            nx[ix[7:4]]   = r[63:32];
            nx[ix[3:0]]   = r[31:0];
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < 16; i++)
            sum[i] = x[i] + x0[i];
    end

`ifdef CC_HCHACHA_EN
    logic hm;
    assign more = !hm && (({1'b0, blk} + 9'd1) < 9'(NBLK));
`else
    logic unused_hmode;
    assign unused_hmode = i_hmode;
    assign more = (({1'b0, blk} + 9'd1) < 9'(NBLK));
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fsm      <= IDLE;
            x        <= '0;
            x0       <= '0;
            rcnt     <= '0;
            blk      <= '0;
            o_stream <= '0;
            o_valid  <= 1'b0;
            o_cnt    <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_wrap   <= 1'b0;
`ifdef CC_HCHACHA_EN
            hm       <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            if (i_abort) begin
                fsm     <= IDLE;
                o_valid <= 1'b0;
                o_busy  <= 1'b0;
            end else begin
                unique case (fsm)
                    IDLE: begin
                        if (i_start) begin
                            x      <= load;
                            x0     <= load;
                            rcnt   <= '0;
                            blk    <= '0;
                            o_wrap <= 1'b0;
                            o_busy <= 1'b1;
`ifdef CC_HCHACHA_EN
                            hm     <= i_hmode;
`endif
                            fsm    <= ROUND;
                        end
                    end
                    ROUND: begin
                        x    <= nx;
                        rcnt <= rcnt + 1'b1;
                        if (last_rnd)
                            fsm <= ADD;
                    end
                    ADD: begin
`ifdef CC_HCHACHA_EN
                        if (hm)
                            o_stream <= {256'd0, x[15:12], x[3:0]};
                        else
                            o_stream <= sum;
`else
                        o_stream <= sum;
`endif
                        o_cnt   <= x0[12];
                        o_valid <= 1'b1;
                        fsm     <= OUT;
                    end
                    OUT: begin
                        if (i_ready) begin
                            o_valid <= 1'b0;
                            if (more) begin
                                x0[12] <= x0[12] + 32'd1;
                                x      <= {x0[15:13], x0[12] + 32'd1, x0[11:0]};
                                if (x0[12] == 32'hffff_ffff)
                                    o_wrap <= 1'b1;
                                blk    <= blk + 8'd1;
                                rcnt   <= '0;
                                fsm    <= ROUND;
                            end else begin
                                o_done <= 1'b1;
                                o_busy <= 1'b0;
                                fsm    <= IDLE;
                            end
                        end
                    end
                    default: fsm <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cc_block_gen.sv
// Directed bench for cc_block_gen: RFC 8439 block vector, multi-block, wrap,
// abort, reset and QR_PAR=4 instances.
module tb_cc_block_gen;

    localparam logic [255:0] K =
        256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    localparam logic [95:0] N = 96'h00000000_4a000000_09000000;

    logic         clk = 1'b0;
    logic         rst, s1, s4, abort, hmode, ready;
    logic [255:0] key;
    logic [95:0]  non;
    logic [31:0]  cnt;

    logic [511:0] st1, st4;
    logic         v1, v4, b1, b4, d1, d4, w1, w4;
    logic [31:0]  c1, c4;

    int checks = 0;
    int failures = 0;
    int n;
    logic [511:0] snap;

    always #5 clk = ~clk;

    cc_block_gen #(.ROUNDS(20), .QR_PAR(1), .NBLK(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(s1), .i_abort(abort),
        .i_hmode(hmode), .i_key(key), .i_non(non), .i_cnt(cnt),
        .o_stream(st1), .o_valid(v1), .i_ready(ready), .o_cnt(c1),
        .o_busy(b1), .o_done(d1), .o_wrap(w1)
    );

    cc_block_gen #(.ROUNDS(20), .QR_PAR(4), .NBLK(1)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(s4), .i_abort(abort),
        .i_hmode(hmode), .i_key(key), .i_non(non), .i_cnt(cnt),
        .o_stream(st4), .o_valid(v4), .i_ready(ready), .o_cnt(c4),
        .o_busy(b4), .o_done(d4), .o_wrap(w4)
    );

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n = index of the current cycle relative to the start/transfer cycle
    task automatic wait_v(input bit sel, output int cyc);
        cyc = 1;
        while ((sel ? v4 : v1) !== 1'b1 && cyc < 300) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        rst = 1'b1; s1 = 1'b0; s4 = 1'b0; abort = 1'b0;
        hmode = 1'b0; ready = 1'b0; key = '0; non = '0; cnt = '0;
        tick();
        tick();
        chk("rst_valid", v1, 0);
        chk("rst_busy", b1, 0);
        chk("rst_done", d1, 0);
        chk("rst_wrap", w1, 0);
        chk("rst_cnt", c1, 0);
        chk("rst_stream", st1, 0);
        chk("rst_valid4", v4, 0);
        rst = 1'b0;
        tick();

        // RFC 8439 block, three blocks with 5-cycle stalls
        key = K; non = N; cnt = 32'd1; s1 = 1'b1;
        tick();
        s1 = 1'b0; key = ~K; non = ~N; cnt = 32'h5555_5555;
        chk("busy_start", b1, 1);
        wait_v(1'b0, n);
        chk("lat_blk1", n, 82);
        chk("w0", st1[31:0], 32'he4e7f110);
        chk("w1", st1[63:32], 32'h15593bd1);
        chk("w12", st1[415:384], 32'hd19c12b5);
        chk("w15", st1[511:480], 32'h4e3c50a2);
        chk("cnt_blk1", c1, 32'd1);
        chk("wrap_blk1", w1, 0);
        snap = st1;
        repeat (5) tick();
        chk("stall1_stream", st1, snap);
        chk("stall1_valid", v1, 1);
        chk("stall1_cnt", c1, 32'd1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("xfer1_nodone", d1, 0);
        chk("xfer1_busy", b1, 1);
        wait_v(1'b0, n);
        chk("lat_blk2", n, 82);
        chk("cnt_blk2", c1, 32'd2);
        snap = st1;
        repeat (5) tick();
        chk("stall2_stream", st1, snap);
        chk("stall2_valid", v1, 1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        wait_v(1'b0, n);
        chk("cnt_blk3", c1, 32'd3);
        chk("pre_done", d1, 0);
        repeat (5) tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("done_pulse", d1, 1);
        chk("done_busy", b1, 0);
        chk("done_valid", v1, 0);
        tick();
        chk("done_clear", d1, 0);

        // counter wrap, then abort while in OUT
        cnt = 32'hffff_ffff; s1 = 1'b1; ready = 1'b1;
        tick();
        s1 = 1'b0;
        wait_v(1'b0, n);
        chk("wrap_cnt1", c1, 32'hffff_ffff);
        chk("wrap_flag1", w1, 0);
        tick();
        wait_v(1'b0, n);
        ready = 1'b0;
        chk("wrap_cnt2", c1, 32'd0);
        chk("wrap_flag2", w1, 1);
        snap = st1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_out_valid", v1, 0);
        chk("abort_out_busy", b1, 0);
        chk("abort_out_done", d1, 0);
        chk("abort_out_wrap", w1, 1);
        chk("abort_out_keep", st1, snap);
        tick();
        chk("abort_out_done2", d1, 0);

        // abort during ROUND, abort beats start, then a clean job
        key = K; non = N; cnt = 32'd1; s1 = 1'b1;
        tick();
        s1 = 1'b0;
        repeat (10) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_rnd_busy", b1, 0);
        chk("abort_rnd_valid", v1, 0);
        tick();
        chk("abort_rnd_done", d1, 0);
        repeat (100) tick();
        chk("abort_rnd_idle", v1, 0);
        abort = 1'b1; s1 = 1'b1;
        tick();
        abort = 1'b0; s1 = 1'b0;
        chk("abort_wins", b1, 0);
        s1 = 1'b1;
        tick();
        s1 = 1'b0;
        chk("restart_wrap_clr", w1, 0);
        wait_v(1'b0, n);
        chk("lat_restart", n, 82);
        chk("restart_w0", st1[31:0], 32'he4e7f110);
        chk("restart_w15", st1[511:480], 32'h4e3c50a2);

        // asynchronous reset while in OUT
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", v1, 0);
        chk("arst_stream", st1, 0);
        chk("arst_cnt", c1, 0);
        chk("arst_busy", b1, 0);
        tick();
        rst = 1'b0;
        tick();

        // four quarter-rounds per cycle
        s4 = 1'b1;
        tick();
        s4 = 1'b0;
        wait_v(1'b1, n);
        chk("lat_qr4", n, 22);
        chk("qr4_w0", st4[31:0], 32'he4e7f110);
        chk("qr4_w1", st4[63:32], 32'h15593bd1);
        chk("qr4_w12", st4[415:384], 32'hd19c12b5);
        chk("qr4_w15", st4[511:480], 32'h4e3c50a2);
        chk("qr4_cnt", c4, 32'd1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("qr4_done", d4, 1);
        chk("qr4_busy", b4, 0);
        chk("qr4_valid", v4, 0);

`ifdef CC_HCHACHA_EN
        hmode = 1'b1; s4 = 1'b1;
        tick();
        s4 = 1'b0; hmode = 1'b0;
        wait_v(1'b1, n);
        chk("hc_lat", n, 22);
        chk("hc_w0", st4[31:0], 32'h837778ab);
        chk("hc_w4", st4[159:128], 32'hd19c12b4);
        chk("hc_upper", st4[511:256], 0);
        chk("hc_cnt", c4, 32'd1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("hc_done", d4, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
